seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a common-anode bank of DIGITS seven-segment digits. It is the parametrised successor of the single-digit BCD decoder. A 4·DIGITS-bit value is loaded through a strobe and committed only at frame boundaries, so a frame never shows a mix of old and new digits. One digit is scanned at a time. Optional features: hex decoding, leading-zero blanking, per-digit blinking and decimal points. It sits between the counter/datapath logic and the board's segment and anode pins.

---
 rtl/seg7_scan_driver_if.sv | 27 ++
 rtl/seg7_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between the counter/datapath logic and the seven-segment scan driver.
// The master side drives value/control; the slave side (the driver) drives the pins.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                en;
    logic                load;
    logic [4*DIGITS-1:0] din;
    logic [DIGITS-1:0]   dp_in;
    logic                hex_en;
    logic                lzb;
    logic [DIGITS-1:0]   blink_mask;
    logic [0:6]          seg;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_start;

    modport master (
        output en, load, din, dp_in, hex_en, lzb, blink_mask,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  en, load, din, dp_in, hex_en, lzb, blink_mask,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver; new values are committed only
// at frame boundaries so a frame never mixes old and new digits.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [FW-1:0]       r_fcnt;
    logic                r_phase;
    logic [4*DIGITS-1:0] r_sh_din;
    logic [DIGITS-1:0]   r_sh_dp;
    logic                r_pend;
    logic [4*DIGITS-1:0] r_disp_din;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [0:6]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_fs;

    logic                w_tc;
    logic                w_wrap;
    logic                w_commit;
    logic [3:0]          w_nib;
    logic                w_dp_req;
    logic                w_blink_sel;
    logic                w_run;
    logic                w_lz_blank;
    logic [0:6]          w_dec;
    logic [0:6]          w_seg;
    logic                w_dp;
    logic [DIGITS-1:0]   w_an;

    assign w_tc     = (r_cnt == CW'(SCAN_DIV - 1));
    assign w_wrap   = (r_idx == IW'(DIGITS - 1));
    assign w_commit = w_tc && w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_idx <= w_wrap ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A load landing in the commit cycle goes to shadow only; the commit takes the old shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_din   <= '0;
            r_sh_dp    <= '0;
            r_pend     <= 1'b0;
            r_disp_din <= '0;
            r_disp_dp  <= '0;
        end else begin
            if (w_commit && r_pend) begin
                r_disp_din <= r_sh_din;
                r_disp_dp  <= r_sh_dp;
            end
            if (bus.load) begin
                r_sh_din <= bus.din;
                r_sh_dp  <= bus.dp_in;
                r_pend   <= 1'b1;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_commit) begin
            if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_nib       = 4'h0;
        w_dp_req    = 1'b0;
        w_blink_sel = 1'b0;
        w_an        = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = r_disp_din[4*i +: 4];
                w_dp_req    = r_disp_dp[i];
                w_blink_sel = bus.blink_mask[i];
                w_an[i]     = 1'b0;
            end
        end

        // Walk down from the top digit; the current digit blanks while the run of zeros holds.
        w_run      = 1'b1;
        w_lz_blank = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_run = w_run && (r_disp_din[4*i +: 4] == 4'h0);
            if ((r_idx == IW'(i)) && w_run) begin
                w_lz_blank = 1'b1;
            end
        end

        case (w_nib)
            4'h0:    w_dec = 7'b0000001;
            4'h1:    w_dec = 7'b1001111;
            4'h2:    w_dec = 7'b0010010;
            4'h3:    w_dec = 7'b0000110;
            4'h4:    w_dec = 7'b1001100;
            4'h5:    w_dec = 7'b0100100;
            4'h6:    w_dec = 7'b0100000;
            4'h7:    w_dec = 7'b0001111;
            4'h8:    w_dec = 7'b0000000;
            4'h9:    w_dec = 7'b0000100;
            4'hA:    w_dec = bus.hex_en ? 7'b0001000 : 7'b1111111;
            4'hB:    w_dec = bus.hex_en ? 7'b1100000 : 7'b1111111;
            4'hC:    w_dec = bus.hex_en ? 7'b0110001 : 7'b1111111;
            4'hD:    w_dec = bus.hex_en ? 7'b1000010 : 7'b1111111;
            4'hE:    w_dec = bus.hex_en ? 7'b0110000 : 7'b1111111;
            default: w_dec = bus.hex_en ? 7'b0111000 : 7'b1111111;
        endcase

        w_seg = w_dec;
        w_dp  = ~w_dp_req;
        if (!bus.en) begin
            w_seg = '1;
            w_dp  = 1'b1;
            w_an  = '1;
        end else if (r_phase && w_blink_sel) begin
            w_seg = '1;
            w_dp  = 1'b1;
        end else if (bus.lzb && w_lz_blank) begin
            w_seg = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= '1;
            r_dp  <= 1'b1;
            r_an  <= '1;
            r_fs  <= 1'b0;
        end else begin
            r_seg <= w_seg;
            r_dp  <= w_dp;
            r_an  <= w_an;
            r_fs  <= w_commit;
        end
    end

    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.an          = r_an;
    assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// k counts rising edges since reset release; outputs at a falling edge show scan position (k-1)%16.
module tb_seg7_scan_driver;
    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   k       = 0;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic align(input int p);
        int guard;
        guard = 0;
        while ((k % FRAME) != p && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL align_timeout k=%0d wanted_pos=%0d", k, p);
        end
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic       efs;
        int         p;
        bus.en = 1'b1; bus.load = 1'b0; bus.din = '0; bus.dp_in = '0;
        bus.hex_en = 1'b1; bus.lzb = 1'b0; bus.blink_mask = '0;
        #1 rst = 1'b1;
        repeat (3) tick();
        n_tests++; if (bus.seg !== 7'b1111111) begin n_fail++; $display("FAIL rst_seg got=%b exp=1111111", bus.seg); end
        n_tests++; if (bus.dp !== 1'b1) begin n_fail++; $display("FAIL rst_dp got=%b exp=1", bus.dp); end
        n_tests++; if (bus.an !== 4'b1111) begin n_fail++; $display("FAIL rst_an got=%b exp=1111", bus.an); end
        n_tests++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs got=%b exp=0", bus.frame_start); end
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            tick();
            p   = (k - 1) % FRAME;
            ea  = ~(4'b0001 << (p / SCAN_DIV));
            efs = ((k % FRAME) == 0);
            n_tests++; if (bus.an !== ea) begin n_fail++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, bus.an, ea); end
            n_tests++; if (bus.seg !== 7'b0000001) begin n_fail++; $display("FAIL scan_seg k=%0d got=%b exp=0000001", k, bus.seg); end
            n_tests++; if (bus.frame_start !== efs) begin n_fail++; $display("FAIL scan_fs k=%0d got=%b exp=%b", k, bus.frame_start, efs); end
        end
        tick();
        rst = 1'b1;
        #1;
        n_tests++; if (bus.seg !== 7'b1111111) begin n_fail++; $display("FAIL midrst_seg got=%b exp=1111111", bus.seg); end
        n_tests++; if (bus.an !== 4'b1111) begin n_fail++; $display("FAIL midrst_an got=%b exp=1111", bus.an); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_commit();
        logic [0:6] exp_seg [4];
        align(5);
        bus.din = 16'h1234; bus.dp_in = 4'b0000; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (11) begin
            n_tests++; if (bus.seg !== 7'b0000001) begin n_fail++; $display("FAIL commit_hold k=%0d got=%b exp=0000001", k, bus.seg); end
            tick();
        end
        exp_seg = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        for (int j = 0; j < FRAME; j++) begin
            n_tests++; if (bus.seg !== exp_seg[j / SCAN_DIV]) begin n_fail++; $display("FAIL commit_1234 pos=%0d got=%b exp=%b", j, bus.seg, exp_seg[j / SCAN_DIV]); end
            tick();
        end
        align(5);
        bus.din = 16'h5678; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        align(15);
        bus.din = 16'h9999; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        exp_seg = '{7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100};
        for (int j = 0; j < FRAME; j++) begin
            n_tests++; if (bus.seg !== exp_seg[j / SCAN_DIV]) begin n_fail++; $display("FAIL commit_old_shadow pos=%0d got=%b exp=%b", j, bus.seg, exp_seg[j / SCAN_DIV]); end
            tick();
        end
        for (int j = 0; j < FRAME; j++) begin
            n_tests++; if (bus.seg !== 7'b0000100) begin n_fail++; $display("FAIL commit_late_load pos=%0d got=%b exp=0000100", j, bus.seg); end
            tick();
        end
    endtask

    task automatic test_hex();
        logic [0:6] exp_seg [4];
        align(5);
        bus.din = 16'hABCD; bus.hex_en = 1'b1; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        align(1);
        exp_seg = '{7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000};
        for (int j = 0; j < FRAME; j++) begin
            n_tests++; if (bus.seg !== exp_seg[j / SCAN_DIV]) begin n_fail++; $display("FAIL hex_on pos=%0d got=%b exp=%b", j, bus.seg, exp_seg[j / SCAN_DIV]); end
            tick();
        end
        bus.hex_en = 1'b0;
        tick();
        repeat (FRAME) begin
            n_tests++; if (bus.seg !== 7'b1111111) begin n_fail++; $display("FAIL hex_off k=%0d got=%b exp=1111111", k, bus.seg); end
            tick();
        end
        bus.hex_en = 1'b1;
    endtask

    task automatic test_lzb();
        logic [0:6] exp_seg [4];
        logic       edp;
        align(5);
        bus.din = 16'h0050; bus.lzb = 1'b1; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        align(1);
        exp_seg = '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
        for (int j = 0; j < FRAME; j++) begin
            n_tests++; if (bus.seg !== exp_seg[j / SCAN_DIV]) begin n_fail++; $display("FAIL lzb_0050 pos=%0d got=%b exp=%b", j, bus.seg, exp_seg[j / SCAN_DIV]); end
            tick();
        end
        align(5);
        bus.din = 16'h0000; bus.dp_in = 4'b0100; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        align(1);
        exp_seg = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
        for (int j = 0; j < FRAME; j++) begin
            edp = ((j / SCAN_DIV) == 2) ? 1'b0 : 1'b1;
            n_tests++; if (bus.seg !== exp_seg[j / SCAN_DIV]) begin n_fail++; $display("FAIL lzb_0000 pos=%0d got=%b exp=%b", j, bus.seg, exp_seg[j / SCAN_DIV]); end
            n_tests++; if (bus.dp !== edp) begin n_fail++; $display("FAIL lzb_dp pos=%0d got=%b exp=%b", j, bus.dp, edp); end
            tick();
        end
        bus.lzb = 1'b0;
        tick();
        align(1);
        for (int j = 0; j < FRAME; j++) begin
            n_tests++; if (bus.seg !== 7'b0000001) begin n_fail++; $display("FAIL lzb_off pos=%0d got=%b exp=0000001", j, bus.seg); end
            tick();
        end
        bus.dp_in = 4'b0000;
    endtask

    task automatic test_blink();
        int         p;
        int         d;
        int         ph;
        int         guard;
        logic [0:6] es;
        logic       edp;
        logic [3:0] ea;
        rst = 1'b1;
        tick();
        bus.din = 16'h0008; bus.dp_in = 4'b0001; bus.blink_mask = 4'b0001;
        bus.lzb = 1'b0; bus.load = 1'b1;
        rst = 1'b0;
        tick();
        bus.load = 1'b0;
        guard = 0;
        while (k < 17 && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) begin n_tests++; n_fail++; $display("FAIL blink_start_timeout k=%0d", k); end
        for (int j = 0; j < 80; j++) begin
            p   = (k - 1) % FRAME;
            d   = p / SCAN_DIV;
            ph  = ((k - 1) / (BLINK_FRAMES * FRAME)) % 2;
            es  = (d != 0) ? 7'b0000001 : ((ph == 1) ? 7'b1111111 : 7'b0000000);
            edp = (d == 0 && ph == 0) ? 1'b0 : 1'b1;
            ea  = ~(4'b0001 << d);
            n_tests++; if (bus.seg !== es) begin n_fail++; $display("FAIL blink_seg k=%0d got=%b exp=%b", k, bus.seg, es); end
            n_tests++; if (bus.dp !== edp) begin n_fail++; $display("FAIL blink_dp k=%0d got=%b exp=%b", k, bus.dp, edp); end
            n_tests++; if (bus.an !== ea) begin n_fail++; $display("FAIL blink_an k=%0d got=%b exp=%b", k, bus.an, ea); end
            tick();
        end
        bus.blink_mask = 4'b0000;
    endtask

    task automatic test_enable();
        int         d;
        logic [0:6] es;
        logic [3:0] ea;
        align(6);
        bus.en = 1'b0;
        repeat (10) begin
            tick();
            n_tests++; if (bus.an !== 4'b1111) begin n_fail++; $display("FAIL en_off_an k=%0d got=%b exp=1111", k, bus.an); end
            n_tests++; if (bus.seg !== 7'b1111111) begin n_fail++; $display("FAIL en_off_seg k=%0d got=%b exp=1111111", k, bus.seg); end
        end
        bus.en = 1'b1;
        repeat (12) begin
            tick();
            d  = ((k - 1) % FRAME) / SCAN_DIV;
            ea = ~(4'b0001 << d);
            es = (d == 0) ? 7'b0000000 : 7'b0000001;
            n_tests++; if (bus.an !== ea) begin n_fail++; $display("FAIL en_on_an k=%0d got=%b exp=%b", k, bus.an, ea); end
            n_tests++; if (bus.seg !== es) begin n_fail++; $display("FAIL en_on_seg k=%0d got=%b exp=%b", k, bus.seg, es); end
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_hex();
        test_lzb();
        test_blink();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
